// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: encoding constants, control codes and the
// decoded bundle carried from decode to execute.
package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // M ops are ALU_MUL + funct3, so their order must follow funct3.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_LUI    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    // LSU codes reuse funct3; mem_wr_sig tells loads from stores.
    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LW  = 3'd2;
    localparam logic [2:0] LSU_LBU = 3'd4;
    localparam logic [2:0] LSU_LHU = 3'd5;
    localparam logic [2:0] LSU_SB  = 3'd0;
    localparam logic [2:0] LSU_SH  = 3'd1;
    localparam logic [2:0] LSU_SW  = 3'd2;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_JAL  = 3'd2;
    localparam logic [2:0] BR_JALR = 3'd3;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    localparam logic [1:0] DO_IMM_RS1 = 2'd0;
    localparam logic [1:0] DO_RS2_RS1 = 2'd1;
    localparam logic [1:0] DO_IMM_PC  = 2'd2;

    localparam logic [1:0] DD_ALU = 2'd0;
    localparam logic [1:0] DD_MEM = 2'd1;
    localparam logic [1:0] DD_PC  = 2'd2;

    typedef struct packed {
        logic        br_sig;
        logic [2:0]  br_op;
        logic [2:0]  lsu_op;
        logic [4:0]  alu_op;
        logic [1:0]  data_origin;
        logic [1:0]  data_dest;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_wr;
        logic        illegal;
    } decoded_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    function automatic logic [4:0] base_alu_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle.
// Illegal encodings return a zeroed bundle with only illegal and the raw register fields set.
module rv_decode
    import rv_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0] instr_i,
    output decoded_t    bundle_o
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_sh;
    logic        w_legal;
    logic        w_wr_rd;
    decoded_t    w_d;

    assign w_opc    = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u  = {instr_i[31:12], 12'h000};
    assign w_imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign w_imm_sh = {27'd0, instr_i[24:20]};

    always_comb begin
        w_d     = '0;
        w_legal = 1'b1;
        w_wr_rd = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_d.alu_op = ALU_LUI;
                w_d.imm    = w_imm_u;
                w_wr_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                w_d.alu_op      = ALU_ADD;
                w_d.data_origin = DO_IMM_PC;
                w_d.imm         = w_imm_u;
                w_wr_rd         = 1'b1;
            end
            OPC_JAL: begin
                w_d.br_sig      = 1'b1;
                w_d.br_op       = BR_JAL;
                w_d.data_origin = DO_IMM_PC;
                w_d.data_dest   = DD_PC;
                w_d.imm         = w_imm_j;
                w_wr_rd         = 1'b1;
            end
            OPC_JALR: begin
                w_legal       = (w_f3 == 3'd0);
                w_d.br_sig    = 1'b1;
                w_d.br_op     = BR_JALR;
                w_d.data_dest = DD_PC;
                w_d.imm       = w_imm_i;
                w_wr_rd       = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal         = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_d.br_sig      = 1'b1;
                w_d.br_op       = w_f3;
                w_d.alu_op      = ALU_SUB;
                w_d.data_origin = DO_RS2_RS1;
                w_d.imm         = w_imm_b;
            end
            OPC_LOAD: begin
                w_legal       = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
                w_d.lsu_op    = w_f3;
                w_d.data_dest = DD_MEM;
                w_d.imm       = w_imm_i;
                w_wr_rd       = 1'b1;
            end
            OPC_STORE: begin
                w_legal       = (w_f3 < 3'd3);
                w_d.lsu_op    = w_f3;
                w_d.data_dest = DD_MEM;
                w_d.mem_wr    = 1'b1;
                w_d.imm       = w_imm_s;
            end
            OPC_OP_IMM: begin
                w_wr_rd = 1'b1;
                if (w_f3 == F3_SLL) begin
                    w_legal    = (w_f7 == F7_BASE);
                    w_d.alu_op = ALU_SLL;
                    w_d.imm    = w_imm_sh;
                end else if (w_f3 == F3_SRL_SRA) begin
                    w_legal    = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    w_d.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    w_d.imm    = w_imm_sh;
                end else begin
                    w_d.alu_op = base_alu_op(w_f3);
                    w_d.imm    = w_imm_i;
                end
            end
            OPC_OP: begin
                w_d.data_origin = DO_RS2_RS1;
                w_wr_rd         = 1'b1;
                if (w_f7 == F7_BASE) begin
                    w_d.alu_op = base_alu_op(w_f3);
                end else if (w_f7 == F7_ALT && w_f3 == F3_ADD_SUB) begin
                    w_d.alu_op = ALU_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == F3_SRL_SRA) begin
                    w_d.alu_op = ALU_SRA;
                end else if (w_f7 == F7_MULDIV && ENABLE_M != 0) begin
                    w_d.alu_op = ALU_MUL + {2'b00, w_f3};
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                w_legal = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_d         = '0;
            w_d.illegal = 1'b1;
        end
        w_d.rs1    = instr_i[19:15];
        w_d.rs2    = instr_i[24:20];
        w_d.rd     = instr_i[11:7];
        w_d.reg_wr = w_legal & w_wr_rd & (instr_i[11:7] != 5'd0);
    end

    assign bundle_o = w_d;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready on both sides, two-entry skid buffer (M drives
// the outputs, S absorbs one bundle under backpressure) so in_ready_o is purely registered.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     pc_o,
    output logic                br_sig_o,
    output logic [2:0]          br_op_o,
    output logic [2:0]          lsu_op_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          data_origin_o,
    output logic [1:0]          data_dest_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [4:0]          reg_addr1_o,
    output logic [4:0]          reg_addr2_o,
    output logic [4:0]          reg_wr_addr_o,
    output logic                reg_wr_sig_o,
    output logic                mem_wr_sig_o,
    output logic                illegal_o,
    output logic [1:0]          dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    occ_state_t      r_state;
    occ_state_t      w_next_state;
    logic            r_in_ready;
    decoded_t        w_dec;
    decoded_t        r_m_bun;
    decoded_t        r_s_bun;
    logic [XLEN-1:0] r_m_pc;
    logic [XLEN-1:0] r_s_pc;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_m_in;
    logic            w_load_s_in;
    logic            w_move_s;

    rv_decode #(.ENABLE_M(ENABLE_M)) u_dec (
        .instr_i  (instr_i),
        .bundle_o (w_dec)
    );

    assign w_accept = in_valid_i & r_in_ready;
    assign w_drain  = (r_state != OCC_EMPTY) & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != OCC_FULL);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: if (w_accept) w_next_state = OCC_ONE;
                OCC_ONE: begin
                    if (w_accept && !w_drain)      w_next_state = OCC_FULL;
                    else if (!w_accept && w_drain) w_next_state = OCC_EMPTY;
                end
                OCC_FULL:  if (w_drain) w_next_state = OCC_ONE;
                default:   w_next_state = OCC_EMPTY;
            endcase
        end
    end

    // FULL never accepts because in_ready_o is low there.
    always_comb begin
        w_load_m_in = 1'b0;
        w_load_s_in = 1'b0;
        w_move_s    = 1'b0;
        if (!flush_i) begin
            case (r_state)
                OCC_EMPTY: w_load_m_in = w_accept;
                OCC_ONE: begin
                    w_load_m_in = w_accept & w_drain;
                    w_load_s_in = w_accept & ~w_drain;
                end
                OCC_FULL:  w_move_s = w_drain;
                default: begin
                    w_load_m_in = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_bun <= '0;
            r_m_pc  <= '0;
            r_s_bun <= '0;
            r_s_pc  <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_bun <= w_dec;
                r_m_pc  <= pc_i;
            end else if (w_move_s) begin
                r_m_bun <= r_s_bun;
                r_m_pc  <= r_s_pc;
            end
            if (w_load_s_in) begin
                r_s_bun <= w_dec;
                r_s_pc  <= pc_i;
            end
        end
    end

    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = (r_state != OCC_EMPTY);
    assign pc_o          = r_m_pc;
    assign br_sig_o      = r_m_bun.br_sig;
    assign br_op_o       = r_m_bun.br_op;
    assign lsu_op_o      = r_m_bun.lsu_op;
    assign alu_op_o      = ALU_OP_W'(r_m_bun.alu_op);
    assign data_origin_o = r_m_bun.data_origin;
    assign data_dest_o   = r_m_bun.data_dest;
    assign imm_o         = XLEN'($signed(r_m_bun.imm));
    assign reg_addr1_o   = r_m_bun.rs1;
    assign reg_addr2_o   = r_m_bun.rs2;
    assign reg_wr_addr_o = r_m_bun.rd;
    assign reg_wr_sig_o  = r_m_bun.reg_wr;
    assign mem_wr_sig_o  = r_m_bun.mem_wr;
    assign illegal_o     = r_m_bun.illegal;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (ENABLE_M=0 and 1) share stimulus and are
// compared against a queue-based occupancy model and a rule-level reference decoder.
module tb_decode_stage;
    import rv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, in_valid_i, out_ready_i;
    logic [31:0] instr_i, pc_i;

    logic        out_valid_0, in_ready_0, br_sig_0, rws_0, mws_0, ill_0;
    logic [31:0] pc_0, imm_0;
    logic [2:0]  br_op_0, lsu_0;
    logic [4:0]  alu_0, ra1_0, ra2_0, rwa_0;
    logic [1:0]  do_0, dd_0, st_0;
    logic        out_valid_1, in_ready_1, br_sig_1, rws_1, mws_1, ill_1;
    logic [31:0] pc_1, imm_1;
    logic [2:0]  br_op_1, lsu_1;
    logic [4:0]  alu_1, ra1_1, ra2_1, rwa_1;
    logic [1:0]  do_1, dd_1, st_1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];   // {pc, instr} of bundles the stage should hold, oldest first

    always #5 clk_i = ~clk_i;

    decode_stage #(.XLEN(32), .ENABLE_M(0), .ALU_OP_W(5)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_0), .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_0),
        .out_ready_i(out_ready_i), .pc_o(pc_0), .br_sig_o(br_sig_0), .br_op_o(br_op_0),
        .lsu_op_o(lsu_0), .alu_op_o(alu_0), .data_origin_o(do_0), .data_dest_o(dd_0),
        .imm_o(imm_0), .reg_addr1_o(ra1_0), .reg_addr2_o(ra2_0), .reg_wr_addr_o(rwa_0),
        .reg_wr_sig_o(rws_0), .mem_wr_sig_o(mws_0), .illegal_o(ill_0), .dbg_state_o(st_0)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1), .ALU_OP_W(5)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_1), .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_1),
        .out_ready_i(out_ready_i), .pc_o(pc_1), .br_sig_o(br_sig_1), .br_op_o(br_op_1),
        .lsu_op_o(lsu_1), .alu_op_o(alu_1), .data_origin_o(do_1), .data_dest_o(dd_1),
        .imm_o(imm_1), .reg_addr1_o(ra1_1), .reg_addr2_o(ra2_1), .reg_wr_addr_o(rwa_1),
        .reg_wr_sig_o(rws_1), .mem_wr_sig_o(mws_1), .illegal_o(ill_1), .dbg_state_o(st_1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ref_reg_op(input logic [2:0] f3);
        logic [4:0] ops [8];
        ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        return ops[f3];
    endfunction

    function automatic decoded_t ref_decode(input logic [31:0] w, input bit en_m);
        decoded_t   d;
        bit         legal = 1'b1;
        bit         writes_rd = 1'b0;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [31:0] imm_i = {{20{w[31]}}, w[31:20]};
        d = '0;
        case (w[6:0])
            7'h37: begin d.alu_op = ALU_LUI; d.imm = {w[31:12], 12'h0}; writes_rd = 1; end
            7'h17: begin
                d.data_origin = DO_IMM_PC; d.imm = {w[31:12], 12'h0}; writes_rd = 1;
            end
            7'h6f: begin
                d.br_sig = 1; d.br_op = BR_JAL; d.data_origin = DO_IMM_PC; d.data_dest = DD_PC;
                d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; writes_rd = 1;
            end
            7'h67: begin
                legal = (f3 == 0); d.br_sig = 1; d.br_op = BR_JALR; d.data_dest = DD_PC;
                d.imm = imm_i; writes_rd = 1;
            end
            7'h63: begin
                legal = !(f3 == 2 || f3 == 3); d.br_sig = 1; d.br_op = f3; d.alu_op = ALU_SUB;
                d.data_origin = DO_RS2_RS1; d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: begin
                legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                d.lsu_op = f3; d.data_dest = DD_MEM; d.imm = imm_i; writes_rd = 1;
            end
            7'h23: begin
                legal = (f3 < 3); d.lsu_op = f3; d.data_dest = DD_MEM; d.mem_wr = 1;
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h13: begin
                writes_rd = 1;
                if (f3 == 1 || f3 == 5) begin
                    d.imm = {27'd0, w[24:20]};
                    d.alu_op = (f3 == 1) ? ALU_SLL : (f7[5] ? ALU_SRA : ALU_SRL);
                    legal = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                end else begin
                    d.imm = imm_i; d.alu_op = ref_reg_op(f3);
                end
            end
            7'h33: begin
                d.data_origin = DO_RS2_RS1; writes_rd = 1;
                if (f7 == 0) d.alu_op = ref_reg_op(f3);
                else if (f7 == 7'h20 && f3 == 0) d.alu_op = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) d.alu_op = ALU_SRA;
                else if (f7 == 7'h01 && en_m) d.alu_op = ALU_MUL + 5'(f3);
                else legal = 0;
            end
            7'h0f, 7'h73: legal = 1;
            default: legal = 0;
        endcase
        if (!legal) begin
            d = '0;
            d.illegal = 1;
        end else begin
            d.reg_wr = writes_rd && (w[11:7] != 0);
        end
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.rd  = w[11:7];
        return d;
    endfunction

    function automatic decoded_t observed(input bit which);
        decoded_t d;
        if (!which) begin
            d.br_sig = br_sig_0; d.br_op = br_op_0; d.lsu_op = lsu_0; d.alu_op = alu_0;
            d.data_origin = do_0; d.data_dest = dd_0; d.imm = imm_0; d.rs1 = ra1_0;
            d.rs2 = ra2_0; d.rd = rwa_0; d.reg_wr = rws_0; d.mem_wr = mws_0; d.illegal = ill_0;
        end else begin
            d.br_sig = br_sig_1; d.br_op = br_op_1; d.lsu_op = lsu_1; d.alu_op = alu_1;
            d.data_origin = do_1; d.data_dest = dd_1; d.imm = imm_1; d.rs1 = ra1_1;
            d.rs2 = ra2_1; d.rd = rwa_1; d.reg_wr = rws_1; d.mem_wr = mws_1; d.illegal = ill_1;
        end
        return d;
    endfunction

    task automatic check_bundle(input string who, input decoded_t o, input decoded_t e);
        check({who, ".br_sig"}, o.br_sig, e.br_sig);
        check({who, ".br_op"}, o.br_op, e.br_op);
        check({who, ".lsu_op"}, o.lsu_op, e.lsu_op);
        check({who, ".alu_op"}, o.alu_op, e.alu_op);
        check({who, ".origin"}, o.data_origin, e.data_origin);
        check({who, ".dest"}, o.data_dest, e.data_dest);
        check({who, ".imm"}, o.imm, e.imm);
        check({who, ".rs1"}, o.rs1, e.rs1);
        check({who, ".rs2"}, o.rs2, e.rs2);
        check({who, ".rd"}, o.rd, e.rd);
        check({who, ".reg_wr"}, o.reg_wr, e.reg_wr);
        check({who, ".mem_wr"}, o.mem_wr, e.mem_wr);
        check({who, ".illegal"}, o.illegal, e.illegal);
    endtask

    task automatic check_outputs();
        check("out_valid0", out_valid_0, exp_q.size() != 0);
        check("out_valid1", out_valid_1, exp_q.size() != 0);
        check("in_ready0", in_ready_0, exp_q.size() < 2);
        check("in_ready1", in_ready_1, exp_q.size() < 2);
        if (exp_q.size() != 0) begin
            check("pc0", pc_0, exp_q[0][63:32]);
            check("pc1", pc_1, exp_q[0][63:32]);
            check_bundle("m0", observed(1'b0), ref_decode(exp_q[0][31:0], 1'b0));
            check_bundle("m1", observed(1'b1), ref_decode(exp_q[0][31:0], 1'b1));
        end
    endtask

    // Called at a falling edge: check, drive, advance one cycle, update the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl, input logic rs);
        bit acc, drn;
        check_outputs();
        in_valid_i = v; instr_i = ins; pc_i = p; out_ready_i = ordy; flush_i = fl; rst_i = rs;
        acc = v && (exp_q.size() < 2);
        drn = ordy && (exp_q.size() > 0);
        @(posedge clk_i);
        if (fl || rs) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({p, ins});
        end
        @(negedge clk_i);
        in_valid_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        int k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = opcs[k];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = '0; pc_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst.out_valid", out_valid_0, 1'b0);
        check("rst.in_ready", in_ready_0, 1'b1);
        check("rst.illegal", ill_0, 1'b0);
        check("rst.pc", pc_0, 32'h0);
        check("rst.imm", imm_0, 32'h0);
        check("rst.alu_op", alu_0, 5'd0);
        check("rst.reg_wr", rws_0, 1'b0);
        check("rst.mem_wr", mws_0, 1'b0);
        check("rst.br_sig", br_sig_0, 1'b0);
        check("rst.rd", rwa_0, 5'd0);
        check("rst.state", st_0, OCC_EMPTY);
        check("rst.out_valid1", out_valid_1, 1'b0);

        // addi x1,x0,5
        step(1, 32'h00500093, 32'h100, 1, 0, 0);
        check("addi.valid", out_valid_0, 1'b1);
        check("addi.alu", alu_0, ALU_ADD);
        check("addi.imm", imm_0, 32'd5);
        check("addi.rd", rwa_0, 5'd1);
        check("addi.reg_wr", rws_0, 1'b1);
        step(0, 0, 0, 1, 0, 0);

        // lw x3,0(x2)
        step(1, 32'h00012183, 32'h104, 1, 0, 0);
        check("lw.lsu", lsu_0, LSU_LW);
        check("lw.dest", dd_0, DD_MEM);
        check("lw.reg_wr", rws_0, 1'b1);
        check("lw.mem_wr", mws_0, 1'b0);
        check("lw.rs1", ra1_0, 5'd2);
        step(0, 0, 0, 1, 0, 0);

        // three offered under backpressure, then released
        step(1, 32'h00100113, 32'h200, 0, 0, 0);
        check("bp.ready_after_1", in_ready_0, 1'b1);
        step(1, 32'h00208193, 32'h204, 0, 0, 0);
        check("bp.ready_after_2", in_ready_0, 1'b0);
        check("bp.state_full", st_0, OCC_FULL);
        step(1, 32'h40208233, 32'h208, 0, 0, 0);
        check("bp.hold_pc", pc_0, 32'h200);
        step(1, 32'h40208233, 32'h208, 1, 0, 0);
        check("bp.second_pc", pc_0, 32'h204);
        step(1, 32'h40208233, 32'h208, 1, 0, 0);
        check("bp.third_pc", pc_0, 32'h208);
        check("bp.third_alu", alu_0, ALU_SUB);
        step(0, 0, 0, 1, 0, 0);
        check("bp.drained", out_valid_0, 1'b0);

        // flush while FULL with a new instruction offered
        step(1, 32'h00100113, 32'h300, 0, 0, 0);
        step(1, 32'h00208193, 32'h304, 0, 0, 0);
        step(1, 32'h00300293, 32'h308, 0, 1, 0);
        check("flush.valid", out_valid_0, 1'b0);
        check("flush.ready", in_ready_0, 1'b1);
        step(0, 0, 0, 1, 0, 0);
        check("flush.gone", out_valid_0, 1'b0);

        // mul x0,x1,x2 on both configurations
        step(1, 32'h02208033, 32'h400, 1, 0, 0);
        check("mul.m0.illegal", ill_0, 1'b1);
        check("mul.m0.reg_wr", rws_0, 1'b0);
        check("mul.m0.mem_wr", mws_0, 1'b0);
        check("mul.m0.br_sig", br_sig_0, 1'b0);
        check("mul.m0.pc", pc_0, 32'h400);
        check("mul.m1.illegal", ill_1, 1'b0);
        check("mul.m1.alu", alu_1, ALU_MUL);
        check("mul.m1.reg_wr", rws_1, 1'b0);

        step(1, 32'hFFFFFFFF, 32'h404, 1, 0, 0);
        check("ones.illegal0", ill_0, 1'b1);
        check("ones.illegal1", ill_1, 1'b1);
        step(0, 0, 0, 1, 0, 0);

        // reset while FULL
        step(1, 32'h00100113, 32'h500, 0, 0, 0);
        step(1, 32'h00208193, 32'h504, 0, 0, 0);
        step(1, 32'h40208233, 32'h508, 0, 0, 1);
        check("rstfull.valid", out_valid_0, 1'b0);
        check("rstfull.ready", in_ready_0, 1'b1);
        step(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RV32I instruction decode stage with an optional M-extension, sitting between fetch and execute. It accepts one instruction plus PC per valid/ready handshake and decodes it into the team's ALU/LSU/branch control bundle. Decoded results are held in a two-entry skid buffer so that execute backpressure never creates a combinational ready path back to fetch. Illegal encodings are flagged rather than silently zeroed, and a flush input supports branch redirect.

## Interface
- XLEN, 32: datapath width of pc and imm (32 only for RV32; 64 reserved)
- ENABLE_M, 0: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 flags them illegal
- ALU_OP_W, 5: width of alu_op_o (base ops plus 8 M ops)

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all buffered and incoming instructions
- in_valid_i  in  1  fetch presents instr_i/pc_i
- in_ready_o  out  1  stage can accept; registered
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction address
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts bundle
- pc_o  out  XLEN  PC of decoded instruction
- br_sig_o / br_op_o  out  1 / 3  branch/jump request and kind
- lsu_op_o  out  3  load/store kind
- alu_op_o  out  ALU_OP_W  ALU operation
- data_origin_o / data_dest_o  out  2 / 2  operand source / result destination
- imm_o  out  XLEN  sign-extended immediate
- reg_addr1_o / reg_addr2_o / reg_wr_addr_o  out  5 each  rs1 / rs2 / rd
- reg_wr_sig_o / mem_wr_sig_o  out  1 / 1  register write / memory write enable
- illegal_o  out  1  bundle is an illegal instruction

## Operation
- Decode rules (fixed):
  - Loads: reg_wr_sig=1, mem_wr_sig=0.
  - Stores: mem_wr_sig=1, reg_wr_sig=0.
  - Branches: reg_wr_sig=0.
  - JAL imm = {sext(i[31]), i[19:12], i[20], i[30:21], 0}.
  - Shift-immediate imm masked to 5 bits.
  - rd=x0 forces reg_wr_sig=0.
- Illegal: unknown opcode, funct3 or funct7, or an M op with ENABLE_M=0. Result is illegal_o=1, every enable 0, br_sig 0, pc_o valid. SYSTEM/FENCE decode as NOP (illegal_o=0, enables 0).
- Buffer: main register M feeds outputs; skid register S catches one bundle when execute stalls.
- States (by occupancy): EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> FULL.
  - ONE + drain, no accept -> EMPTY.
  - ONE + accept + drain -> ONE (M replaced).
  - FULL + drain -> ONE (S moves to M).
- Accept = in_valid_i & in_ready_o. Drain = out_valid_o & out_ready_i.
- in_ready_o = registered (next state != FULL).
- Order is strictly preserved; no bundle is duplicated or dropped except by flush.
- flush_i: next cycle state EMPTY, out_valid_o=0, in_ready_o=1. An accept in the flush cycle is discarded. Flush takes priority over all else.

## Timing
- Latency: instruction accepted at edge N appears on outputs after edge N (valid in cycle N+1) when state was EMPTY or draining.
- Throughput: 1 instruction/cycle with out_ready_i held high.
- Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Reset values: out_valid_o=0, in_ready_o=1, illegal_o=0, all control/address/imm/pc outputs 0.
- Reset mid-operation: both entries dropped on the same edge; no bundle survives.
- No combinational path from out_ready_i to in_ready_o.

## Structure
- Shared package rv_pkg: opcode, funct3 and funct7 constants; ALU_*, LSU_*, BR_* codes (ALU_OP_W wide, M ops appended); data origin/dest codes (IMM_RS1, RS2_RS1, IMM_PC; ALU, MEM, PC); decoded-bundle struct.
- Sub-module rv_decode: purely combinational instr -> bundle + illegal, parametrised by ENABLE_M. decode_stage instantiates it plus the M/S registers and occupancy control.

## Test plan
- 0x00500093 (addi x1,x0,5), out_ready_i=1 -> next cycle out_valid_o=1, alu_op=ALU_ADD, imm_o=5, reg_wr_addr_o=1, reg_wr_sig_o=1.
- 0x00012183 (lw x3,0(x2)) -> lsu_op=LSU_LW, data_dest=MEM, reg_wr_sig=1, mem_wr_sig=0, reg_addr1_o=2.
- Three back-to-back instructions with out_ready_i=0 -> in_ready_o drops after the 2nd accept; release yields 1st, 2nd, 3rd in order with no gaps or duplicates.
- flush_i in FULL state with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed instruction never appears.
- 0x02208033 (mul x0,x1,x2): ENABLE_M=0 -> illegal_o=1, all enables 0. ENABLE_M=1 -> alu_op=ALU_MUL, reg_wr_sig=0 (rd=x0).
- 0xFFFFFFFF -> illegal_o=1. rst_i asserted while FULL -> next cycle out_valid_o=0, in_ready_o=1.
